// File: rtl/delay_line_arbiter_pkg.sv
// Shared settings for the delay-line arbiter: datapath geometry, FSM states
// and the per-beat ownership tag carried alongside the datapath.
package package_settings;

  localparam int SIZE_DATA       = 8;
  localparam int SIZE_SHIFT_REG  = 8;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int ID_W            = $clog2(NUM_REQ_DEFAULT);
  localparam int LATENCY         = SIZE_SHIFT_REG + 1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/delay_line_arbiter_if.sv
// Requester-side bus of the arbiter: per-requester valid/data/ready plus the
// tagged result stream coming back out of the shared datapath.
interface delay_line_arbiter_if
  import package_settings::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][SIZE_DATA-1:0] req_data;
    logic [NUM_REQ-1:0]                req_ready;
    logic                              out_valid;
    logic signed [SIZE_DATA-1:0]       out_data;
    logic [ID_W-1:0]                   out_id;

    modport master (
        output req_valid, req_data,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/delay_line_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted bit of req strictly after
// ptr, wrapping, so ptr itself is considered last.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/delay_line_arbiter.sv
// Round-robin burst arbiter sharing one external delay-line datapath between
// NUM_REQ requesters, with a source-ID tag pipe and a drain sequence.
module delay_line_arbiter
  import package_settings::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    delay_line_arbiter_if.slave         bus,
    input  logic                        drain_req,
    output logic                        drain_done,
    output logic [SIZE_DATA-1:0]        dp_input_data,
    output logic                        dp_enable,
    input  logic signed [SIZE_DATA-1:0] dp_output_data,
    output logic                        busy
);

    localparam int L      = LATENCY;
    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BCNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic              drain_hold, drain_hold_nxt;
    tag_t              tags [L];

    logic              beat;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   pick_ptr;
    logic              pipe_empty_next;

    assign beat     = (state == BURST) && bus.req_valid[owner];
    assign pick_ptr = (state == BURST) ? owner : rr_ptr;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The pipe is empty from the next cycle on once only the last stage can
    // still hold a beat; drain_done therefore coincides with the final output.
    always_comb begin
        pipe_empty_next = 1'b1;
        for (int k = 0; k < L - 1; k++) begin
            if (tags[k].valid) pipe_empty_next = 1'b0;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rr_ptr_nxt     = rr_ptr;
        beat_cnt_nxt   = beat_cnt;
        drain_hold_nxt = drain_hold && drain_req;
        drain_done     = 1'b0;
        case (state)
            IDLE: begin
                if (drain_req) begin
                    if (!drain_hold) state_nxt = DRAIN;
                end else if (pick_found) begin
                    state_nxt    = BURST;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!beat || beat_cnt == BCNT_W'(MAX_BURST - 1)) begin
                    rr_ptr_nxt   = owner;
                    beat_cnt_nxt = '0;
                    if (drain_req)       state_nxt = DRAIN;
                    else if (pick_found) owner_nxt = pick_idx;
                    else                 state_nxt = IDLE;
                end else begin
                    beat_cnt_nxt = beat_cnt + BCNT_W'(1);
                end
            end
            DRAIN: begin
                if (pipe_empty_next) begin
                    drain_done     = 1'b1;
                    state_nxt      = IDLE;
                    // A still-high drain_req must drop before another drain.
                    drain_hold_nxt = drain_req;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            drain_hold <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rr_ptr     <= rr_ptr_nxt;
            beat_cnt   <= beat_cnt_nxt;
            drain_hold <= drain_hold_nxt;
        end
    end

    // NOTE: the tag pipe is a register array but must be reset: its valid
    // bits gate dp_enable and out_valid, and stale ones would leak beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < L; k++) tags[k] <= '0;
        end else begin
            tags[0] <= '{valid: beat, id: owner};
            for (int k = 1; k < L; k++) tags[k] <= tags[k-1];
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == BURST) bus.req_ready[owner] = 1'b1;
    end

    assign dp_input_data = beat ? bus.req_data[owner] : '0;
    assign dp_enable     = tags[L-2].valid;
    assign bus.out_valid = tags[L-1].valid;
    assign bus.out_id    = tags[L-1].id;
    // Masked so the output bus is zero while reset holds the tags invalid.
    assign bus.out_data  = tags[L-1].valid ? dp_output_data : '0;
    assign busy          = (state != IDLE) || !pipe_empty_next || tags[L-1].valid;

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench: directed scenarios plus a randomized run, with a beat scoreboard
// that expects every accepted beat back L cycles later with its owner ID.
module tb_delay_line_arbiter;
    import package_settings::*;

    localparam int N    = NUM_REQ_DEFAULT;
    localparam int MAXB = 4;
    localparam int L    = SIZE_SHIFT_REG + 1;
    localparam int LOGN = 64;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        drain_req;
    logic                        drain_done;
    logic [SIZE_DATA-1:0]        dp_input_data;
    logic                        dp_enable;
    logic signed [SIZE_DATA-1:0] dp_output_data;
    logic                        busy;
    logic [SIZE_DATA-1:0]        dp_sr [SIZE_SHIFT_REG];

    delay_line_arbiter_if #(.NUM_REQ(N)) bus ();

    delay_line_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .dp_input_data  (dp_input_data),
        .dp_enable      (dp_enable),
        .dp_output_data (dp_output_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Datapath behind the arbiter: SIZE_SHIFT_REG stages plus an enabled output register.
    always_ff @(posedge clk) begin
        dp_sr[0] <= dp_input_data;
        for (int s = 1; s < SIZE_SHIFT_REG; s++) dp_sr[s] <= dp_sr[s-1];
        dp_output_data <= dp_enable ? $signed(dp_sr[SIZE_SHIFT_REG-1]) : '0;
    end

    typedef struct {
        logic [SIZE_DATA-1:0] data;
        int                   id;
        int                   cyc;
    } beat_t;

    beat_t                sb [$];
    logic [SIZE_DATA-1:0] src_q [N][$];
    logic [N-1:0]         en;
    int                   cyc, t0, n_vec, n_err;
    logic                 last_drain;
    logic [N-1:0]         fire_log  [LOGN];
    logic                 outv_log  [LOGN];
    logic [ID_W-1:0]      outid_log [LOGN];
    logic [SIZE_DATA-1:0] outd_log  [LOGN];
    logic                 drain_log [LOGN];
    logic                 busy_log  [LOGN];
    logic [SIZE_DATA-1:0] sent [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = en[i] && (src_q[i].size() > 0);
            bus.req_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    // One clock: sample at negedge, score outputs, then advance requesters.
    task automatic tick();
        logic [N-1:0] fire;
        int           rel;
        @(negedge clk);
        rel  = cyc - t0;
        fire = bus.req_valid & bus.req_ready;
        check("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
        if (sb.size() > 0 && sb[0].cyc + L == cyc) begin
            check("sb_out_valid", bus.out_valid, 1);
            check("sb_out_id", bus.out_id, sb[0].id);
            check("sb_out_data", $unsigned(bus.out_data), sb[0].data);
            void'(sb.pop_front());
        end else begin
            check("sb_out_idle", {bus.out_valid, $unsigned(bus.out_data)}, 0);
        end
        for (int i = 0; i < N; i++)
            if (fire[i]) sb.push_back('{bus.req_data[i], i, cyc});
        last_drain = drain_done;
        if (rel >= 0 && rel < LOGN) begin
            fire_log[rel]  = fire;
            outv_log[rel]  = bus.out_valid;
            outid_log[rel] = bus.out_id;
            outd_log[rel]  = $unsigned(bus.out_data);
            drain_log[rel] = drain_done;
            busy_log[rel]  = busy;
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        drain_req = 1'b0;
        en        = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb.delete();
        drive();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic start();
        for (int r = 0; r < LOGN; r++) begin
            fire_log[r] = '0; outv_log[r] = 1'b0; outid_log[r] = '0;
            outd_log[r] = '0; drain_log[r] = 1'b0; busy_log[r] = 1'b0;
        end
        t0 = cyc;
        drive();
    endtask

    initial begin
        logic seen;
        int   exp_id;
        n_vec = 0; n_err = 0; cyc = 0; t0 = 0;
        reset_dut();
        check("rst_ready", bus.req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_dp_enable", dp_enable, 0);
        check("rst_out_valid", bus.out_valid, 0);

        // Single requester 2, three beats.
        src_q[2].push_back(8'h11); src_q[2].push_back(8'h22); src_q[2].push_back(8'h33);
        en = 4'b0100;
        start();
        repeat (22) tick();
        for (int r = 0; r < 8; r++)
            check($sformatf("t1_beat[%0d]", r), fire_log[r], (r >= 1 && r <= 3) ? 4'b0100 : 4'b0000);
        for (int r = 9; r <= 13; r++)
            check($sformatf("t1_out_valid[%0d]", r), outv_log[r], (r >= 10 && r <= 12) ? 1 : 0);
        check("t1_data0", outd_log[10], 8'h11);
        check("t1_data1", outd_log[11], 8'h22);
        check("t1_data2", outd_log[12], 8'h33);
        check("t1_id", outid_log[11], 2);
        check("t1_busy_last", busy_log[12], 1);
        check("t1_busy_drop", busy_log[13], 0);

        // All four requesters held valid.
        reset_dut();
        for (int i = 0; i < N; i++)
            repeat (8) src_q[i].push_back(SIZE_DATA'($urandom));
        en = '1;
        start();
        repeat (31) tick();
        for (int r = 1; r <= 20; r++) begin
            exp_id = ((r - 1) / MAXB) % N;
            check($sformatf("t2_grant[%0d]", r), fire_log[r], 32'(1) << exp_id);
            check($sformatf("t2_out_valid[%0d]", r + 9), outv_log[r+9], 1);
            check($sformatf("t2_out_id[%0d]", r + 9), outid_log[r+9], exp_id);
        end

        // Owner 0 drops valid after two beats; requester 1 follows.
        reset_dut();
        repeat (2) src_q[0].push_back(SIZE_DATA'($urandom));
        repeat (3) src_q[1].push_back(SIZE_DATA'($urandom));
        en = 4'b0011;
        start();
        repeat (18) tick();
        for (int r = 1; r <= 6; r++)
            check($sformatf("t3_beat[%0d]", r), fire_log[r], (r <= 2) ? 4'b0001 : (r == 3) ? 4'b0000 : 4'b0010);
        for (int r = 10; r <= 15; r++)
            check($sformatf("t3_out_valid[%0d]", r), outv_log[r], (r == 12) ? 0 : 1);
        check("t3_out_id_a", outid_log[11], 0);
        check("t3_out_id_b", outid_log[13], 1);

        // Drain requested mid-burst.
        reset_dut();
        repeat (6) src_q[0].push_back(SIZE_DATA'($urandom));
        repeat (4) src_q[3].push_back(SIZE_DATA'($urandom));
        en = 4'b1001;
        start();
        repeat (2) tick();
        drain_req = 1'b1;
        repeat (18) tick();
        drain_req = 1'b0;
        repeat (8) tick();
        for (int r = 1; r <= 21; r++)
            check($sformatf("t4_beat[%0d]", r), fire_log[r], (r <= 4) ? 4'b0001 : (r == 21) ? 4'b1000 : 4'b0000);
        for (int r = 0; r <= 25; r++)
            check($sformatf("t4_drain_done[%0d]", r), drain_log[r], (r == 13) ? 1 : 0);
        check("t4_idle_after_drain", busy_log[14], 0);

        // Reset with five beats in flight.
        reset_dut();
        repeat (5) src_q[1].push_back(SIZE_DATA'($urandom));
        en = 4'b0010;
        start();
        repeat (7) tick();
        check("t5_in_flight", busy, 1);
        reset = 1'b1;
        sb.delete();
        en = '0;
        drive();
        #1;
        check("t5_rst_out_valid", bus.out_valid, 0);
        check("t5_rst_outputs", {bus.req_ready, dp_enable, dp_input_data, bus.out_valid,
                                 $unsigned(bus.out_data), bus.out_id, drain_done, busy}, 0);
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("t5_no_stale[%0d]", k), {bus.out_valid, $unsigned(bus.out_data), busy}, 0);
        end

        // Sole requester 1, ten beats back-to-back.
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            sent[k] = SIZE_DATA'($urandom);
            src_q[1].push_back(sent[k]);
        end
        en = 4'b0010;
        start();
        repeat (22) tick();
        for (int r = 1; r <= 11; r++)
            check($sformatf("t6_beat[%0d]", r), fire_log[r], (r <= 10) ? 4'b0010 : 4'b0000);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t6_out_valid[%0d]", k), outv_log[10+k], 1);
            check($sformatf("t6_out_id[%0d]", k), outid_log[10+k], 1);
            check($sformatf("t6_out_data[%0d]", k), outd_log[10+k], sent[k]);
        end

        // Randomized traffic with occasional drains.
        reset_dut();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(0, 3) != 0);
                while (src_q[i].size() < 3) src_q[i].push_back(SIZE_DATA'($urandom));
            end
            if (!drain_req) drain_req = ($urandom_range(0, 49) == 0);
            else            drain_req = ($urandom_range(0, 9) != 0);
            drive();
            tick();
        end
        en = '0;
        drain_req = 1'b0;
        drive();
        tick();
        drain_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            seen = last_drain;
        end
        check("final_drain_done", seen, 1);
        repeat (2) tick();
        check("final_sb_empty", sb.size(), 0);
        check("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
